// File: rtl/matop_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// matop_pkg
// Shared types and constants for the 2x2 matrix-operation sequencer.
//   - ELEM_W / RES_W : operand and result element widths
//   - op_e           : command opcodes (6 and 7 are illegal)
//   - state_e        : controller states
//   - STEPS_*        : COMPUTE cycles per opcode, plus op_steps()
//   - IDX_*, elem_lsb: element indices and packing offsets for the
//                      {x11,x12,x21,x22} bus layout
// Configuration macro: MATOP_DET_EN (enables the determinant opcode).
// ---------------------------------------------------------------------------
package matop_pkg;

  localparam int ELEM_W = 2;
  localparam int RES_W  = 2 * ELEM_W + 2;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_SCALE = 3'd3,
    OP_TRANS = 3'd4,
    OP_DET   = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [3:0] STEPS_ADD     = 4'd1;
  localparam logic [3:0] STEPS_SUB     = 4'd1;
  localparam logic [3:0] STEPS_MUL     = 4'd8;
  localparam logic [3:0] STEPS_SCALE   = 4'd4;
  localparam logic [3:0] STEPS_TRANS   = 4'd1;
  localparam logic [3:0] STEPS_DET     = 4'd2;
  localparam logic [3:0] STEPS_ILLEGAL = 4'd1;

  // Element indices in the packed {x11,x12,x21,x22} order.
  localparam logic [1:0] IDX_11 = 2'd0;
  localparam logic [1:0] IDX_12 = 2'd1;
  localparam logic [1:0] IDX_21 = 2'd2;
  localparam logic [1:0] IDX_22 = 2'd3;

  // Number of COMPUTE cycles for an opcode. Without the determinant
  // feature, op 5 is just another illegal opcode.
  function automatic logic [3:0] op_steps(op_e op);
    case (op)
      OP_ADD:   return STEPS_ADD;
      OP_SUB:   return STEPS_SUB;
      OP_MUL:   return STEPS_MUL;
      OP_SCALE: return STEPS_SCALE;
      OP_TRANS: return STEPS_TRANS;
`ifdef MATOP_DET_EN
      OP_DET:   return STEPS_DET;
`endif
      default:  return STEPS_ILLEGAL;
    endcase
  endfunction

  // LSB position of element idx (0 = x11) in a bus of four w-bit elements;
  // x11 sits in the most significant slot.
  function automatic int elem_lsb(int idx, int w);
    return (3 - idx) * w;
  endfunction

endpackage

// File: rtl/matop_sequencer_mul2x2.sv
// ---------------------------------------------------------------------------
// mul2x2
// Combinational unsigned W x W multiplier, the single multiplier shared by
// every partial product of the sequencer.
// Ports:
//   a, b : unsigned operands, W bits each
//   p    : unsigned product, 2*W bits
// ---------------------------------------------------------------------------
module mul2x2 #(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/matop_sequencer.sv
// ---------------------------------------------------------------------------
// matop_sequencer
// Command-driven controller for 2x2 matrix operations (add, subtract,
// multiply, scalar multiply, transpose, determinant). All partial products
// go through one shared mul2x2 instance, one product per COMPUTE cycle.
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   cmd_valid   : command present          cmd_ready : accepting (IDLE only)
//   cmd_op      : opcode (op_e)            cmd_a/b   : packed {x11,x12,x21,x22}
//   res_valid   : result held (DONE)       res_ready : consumer accepts
//   res_data    : packed {c11,c12,c21,c22}, RES_W-bit two's complement each
//   res_err     : result is for an illegal / compiled-out opcode
//   busy        : COMPUTE or DONE
// Configuration macro: MATOP_DET_EN -- when undefined, op 5 (DET) is illegal
// and the determinant operand routing and subtractor are not built.
// ---------------------------------------------------------------------------
module matop_sequencer
  import matop_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [4*ELEM_W-1:0]   cmd_a,
  input  logic [4*ELEM_W-1:0]   cmd_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*RES_W-1:0]    res_data,
  output logic                  res_err,
  output logic                  busy
);

  typedef logic        [ELEM_W-1:0] elem_t;
  typedef logic signed [RES_W-1:0]  res_t;

  function automatic res_t zext(elem_t x);
    return res_t'({{(RES_W - ELEM_W){1'b0}}, x});
  endfunction

  state_e              state_q, state_d;
  op_e                 op_q;
  elem_t               a_q   [4];
  elem_t               b_q   [4];
  res_t                acc_q [4];
  logic                err_q;
  logic [2:0]          step_q;

  logic                accept;
  logic                last_step;
  logic [1:0]          x_sel, y_sel, dst_sel;
  logic                y_from_a;
`ifdef MATOP_DET_EN
  logic                sub_en;
`endif
  elem_t               mul_x, mul_y;
  logic [2*ELEM_W-1:0] prod;
  res_t                prod_ext;
  res_t                acc_upd;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign last_step = ({1'b0, step_q} + 4'd1) == op_steps(op_q);

  // ---------------------------------------------------------------- FSM
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_valid) state_d = ST_COMPUTE;
      ST_COMPUTE: if (last_step) state_d = ST_DONE;
      ST_DONE:    if (res_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------- multiplier routing
  // MUL step s: element e = s[2:1] (row s[2], column s[1]) and term t = s[0],
  // so the product is a[row][t] * b[t][col].
  always_comb begin
    x_sel    = IDX_11;
    y_sel    = IDX_11;
    dst_sel  = IDX_11;
    y_from_a = 1'b0;
`ifdef MATOP_DET_EN
    sub_en   = 1'b0;
`endif
    case (op_q)
      OP_MUL: begin
        dst_sel = step_q[2:1];
        x_sel   = {step_q[2], step_q[0]};
        y_sel   = {step_q[0], step_q[1]};
      end
      OP_SCALE: begin
        dst_sel = step_q[1:0];
        x_sel   = step_q[1:0];
        y_sel   = IDX_11;
      end
`ifdef MATOP_DET_EN
      // Step 0 loads a11*a22 into c11, step 1 subtracts a12*a21.
      OP_DET: begin
        dst_sel  = IDX_11;
        x_sel    = step_q[0] ? IDX_12 : IDX_11;
        y_sel    = step_q[0] ? IDX_21 : IDX_22;
        y_from_a = 1'b1;
        sub_en   = step_q[0];
      end
`endif
      default: ;
    endcase
  end

  assign mul_x = a_q[x_sel];
  assign mul_y = y_from_a ? a_q[y_sel] : b_q[y_sel];

  mul2x2 #(.W(ELEM_W)) u_mul (
    .a (mul_x),
    .b (mul_y),
    .p (prod)
  );

  assign prod_ext = res_t'({{(RES_W - 2*ELEM_W){1'b0}}, prod});

  // Accumulators are cleared on accept, so SCALE and DET step 0 can share
  // the MUL accumulate path instead of needing a separate load.
`ifdef MATOP_DET_EN
  assign acc_upd = sub_en ? acc_q[dst_sel] - prod_ext
                          : acc_q[dst_sel] + prod_ext;
`else
  assign acc_upd = acc_q[dst_sel] + prod_ext;
`endif

  // ------------------------------------------------------------ datapath
  // NOTE: the accumulator array is reset along with the rest because it
  // drives res_data directly and must read as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_ADD;
      step_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else if (accept) begin
      op_q   <= op_e'(cmd_op);
      step_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i]   <= cmd_a[elem_lsb(i, ELEM_W) +: ELEM_W];
        b_q[i]   <= cmd_b[elem_lsb(i, ELEM_W) +: ELEM_W];
        acc_q[i] <= '0;
      end
    end else if (state_q == ST_COMPUTE) begin
      step_q <= step_q + 3'd1;
      case (op_q)
        OP_ADD:
          for (int i = 0; i < 4; i++) acc_q[i] <= zext(a_q[i]) + zext(b_q[i]);
        OP_SUB:
          for (int i = 0; i < 4; i++) acc_q[i] <= zext(a_q[i]) - zext(b_q[i]);
        OP_TRANS: begin
          acc_q[IDX_11] <= zext(a_q[IDX_11]);
          acc_q[IDX_12] <= zext(a_q[IDX_21]);
          acc_q[IDX_21] <= zext(a_q[IDX_12]);
          acc_q[IDX_22] <= zext(a_q[IDX_22]);
        end
        OP_MUL:   acc_q[dst_sel] <= acc_upd;
        OP_SCALE: acc_q[dst_sel] <= acc_upd;
`ifdef MATOP_DET_EN
        OP_DET:   acc_q[dst_sel] <= acc_upd;
`endif
        // Illegal opcodes leave the cleared accumulators at zero.
        default:  err_q <= 1'b1;
      endcase
    end
  end

  // ------------------------------------------------------------- outputs
  always_comb begin
    res_data = '0;
    for (int i = 0; i < 4; i++) res_data[elem_lsb(i, RES_W) +: RES_W] = acc_q[i];
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_err   = err_q;

endmodule
